// File: rtl/adc_spi_responder_if.sv
// Serial link between the ADC controller (master) and the ADC responder (slave).
// ADC_SCLK idles high, ADC_CS_N is active low, ADC_SDAT carries conversion data MSB first.
interface adc_spi_responder_if;
  logic ADC_SCLK;
  logic ADC_CS_N;
  logic ADC_SADDR;
  logic ADC_SDAT;

  modport master (
    output ADC_SCLK,
    output ADC_CS_N,
    output ADC_SADDR,
    input  ADC_SDAT
  );

  modport slave (
    input  ADC_SCLK,
    input  ADC_CS_N,
    input  ADC_SADDR,
    output ADC_SDAT
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC for loopback of the acquisition path.
// Each 16-bit frame returns 4 leading zeros plus the sample of the channel that
// was addressed in the previous frame; the address bits for the next frame are
// captured on rising edges 3..5 of the current one.
// Optional build macro ADC_SPI_RESPONDER_RAMP_EN: replaces CH0..CH7 with eight
// internal ramps that advance each time their channel completes a frame.
//
// state | meaning
// IDLE  | waiting for an accepted CS_N falling edge
// SHIFT | frame in flight, counting SCLK rising edges and shifting data out
// HOLD  | 16 bits done, ignoring SCLK until CS_N returns high
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLOCK,
  input  logic                RESET,
  adc_spi_responder_if.slave  adc,
  input  logic [DATA_W-1:0]   CH0,
  input  logic [DATA_W-1:0]   CH1,
  input  logic [DATA_W-1:0]   CH2,
  input  logic [DATA_W-1:0]   CH3,
  input  logic [DATA_W-1:0]   CH4,
  input  logic [DATA_W-1:0]   CH5,
  input  logic [DATA_W-1:0]   CH6,
  input  logic [DATA_W-1:0]   CH7,
  output logic                FRAME_DONE,
  output logic                FRAME_ERR,
  output logic [2:0]          LAST_ADDR
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, saddr_sync, prime_sync;
  logic                   s_sclk, s_cs, s_saddr, primed;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   armed;
  logic [15:0]            shift_reg;
  logic [3:0]             rise_cnt;
  logic [2:0]             next_addr, conv_addr;
  logic [DATA_W-1:0]      ch_sel;
  logic                   load, capture, shift, done, abort;

  assign s_sclk  = sclk_sync[SYNC_STAGES-1];
  assign s_cs    = cs_sync[SYNC_STAGES-1];
  assign s_saddr = saddr_sync[SYNC_STAGES-1];
  // The chain outputs only reflect the pins once a 1 has walked through the
  // whole chain; before that they still show reset values, which must not arm.
  assign primed  = prime_sync[SYNC_STAGES-1];

  assign sclk_rise = s_sclk & ~sclk_d;
  assign sclk_fall = ~s_sclk & sclk_d;
  assign cs_rise   = s_cs & ~cs_d;
  assign cs_fall   = ~s_cs & cs_d;

  assign adc.ADC_SDAT = (state == SHIFT) & shift_reg[15];

  // Synchronise the serial pins into CLOCK and keep one delayed copy for edges.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sclk_sync  <= '1;
      cs_sync    <= '1;
      saddr_sync <= '0;
      prime_sync <= '0;
      sclk_d     <= 1'b1;
      cs_d       <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], adc.ADC_SCLK};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], adc.ADC_CS_N};
      saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], adc.ADC_SADDR};
      prime_sync <= {prime_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d     <= s_sclk;
      cs_d       <= s_cs;
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; a CS_N rise always beats a same-cycle SCLK edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (sclk_rise) begin
          if (rise_cnt == 4'd15) begin
            state_nxt = HOLD;
            done      = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end else if (sclk_fall && rise_cnt != 4'd0) begin
          shift = 1'b1;
        end
      end
      HOLD: begin
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: arming, data load/shift, address capture and status pulses.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      armed      <= 1'b0;
      shift_reg  <= '0;
      rise_cnt   <= '0;
      next_addr  <= '0;
      conv_addr  <= '0;
      LAST_ADDR  <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      FRAME_DONE <= done;
      FRAME_ERR  <= abort;
      if (load)                                   armed <= 1'b0;
      else if (state == IDLE && primed && s_cs)   armed <= 1'b1;
      if (load) begin
        shift_reg <= {{(16-DATA_W){1'b0}}, ch_sel};
        rise_cnt  <= '0;
      end
      if (capture) begin
        rise_cnt <= rise_cnt + 4'd1;
        case (rise_cnt)
          4'd2:    next_addr[2] <= s_saddr;
          4'd3:    next_addr[1] <= s_saddr;
          4'd4:    next_addr[0] <= s_saddr;
          default: ;
        endcase
      end
      if (shift) shift_reg <= {shift_reg[14:0], 1'b0};
      if (done) begin
        LAST_ADDR <= next_addr;
        conv_addr <= next_addr;
      end
    end
  end

`ifdef ADC_SPI_RESPONDER_RAMP_EN
  logic [DATA_W-1:0] ramp [8];

  // Each ramp advances only when its channel has just been sent in full.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < 8; k++) ramp[k] <= DATA_W'(k * 256);
    end else if (done) begin
      ramp[conv_addr] <= ramp[conv_addr] + 1'b1;
    end
  end

  // Sample source is the ramp of the current conversion channel.
  always_comb begin
    ch_sel = ramp[conv_addr];
  end
`else
  // Sample source is the CH input of the current conversion channel.
  always_comb begin
    ch_sel = CH0;
    case (conv_addr)
      3'd0: ch_sel = CH0;
      3'd1: ch_sel = CH1;
      3'd2: ch_sel = CH2;
      3'd3: ch_sel = CH3;
      3'd4: ch_sel = CH4;
      3'd5: ch_sel = CH5;
      3'd6: ch_sel = CH6;
      3'd7: ch_sel = CH7;
      default: ch_sel = CH0;
    endcase
  end
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives ADC controller frames and checks the
// returned words, status pulses and LAST_ADDR against a frame-level model
// (conversion channel, last address, per-channel values or ramps).
module tb_adc_spi_responder;
  localparam int H = 8;  // CLOCKs per SCLK half period

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        sclk, cs_n, saddr;
  logic [11:0] ch_arr [8];
  logic        FRAME_DONE, FRAME_ERR;
  logic [2:0]  LAST_ADDR;

  adc_spi_responder_if bus ();
  assign bus.ADC_SCLK  = sclk;
  assign bus.ADC_CS_N  = cs_n;
  assign bus.ADC_SADDR = saddr;

  adc_spi_responder #(.DATA_W(12), .SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .adc(bus),
    .CH0(ch_arr[0]), .CH1(ch_arr[1]), .CH2(ch_arr[2]), .CH3(ch_arr[3]),
    .CH4(ch_arr[4]), .CH5(ch_arr[5]), .CH6(ch_arr[6]), .CH7(ch_arr[7]),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .LAST_ADDR(LAST_ADDR)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int err_seen = 0;
  bit done_prev = 0;
  bit err_prev = 0;
  bit quiet = 0;

  logic [2:0]  conv_m, last_m;
`ifdef ADC_SPI_RESPONDER_RAMP_EN
  logic [11:0] ramp_m [8];
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic model_reset();
    conv_m = 3'd0;
    last_m = 3'd0;
`ifdef ADC_SPI_RESPONDER_RAMP_EN
    for (int k = 0; k < 8; k++) ramp_m[k] = 12'(k * 256);
`endif
  endtask

  function automatic logic [11:0] model_val(input logic [2:0] c);
`ifdef ADC_SPI_RESPONDER_RAMP_EN
    return ramp_m[c];
`else
    return ch_arr[c];
`endif
  endfunction

  // Per-cycle monitor: pulse widths, reset values, and idle-time outputs.
  always @(posedge CLOCK) begin
    #1;
    if (FRAME_DONE) begin
      done_seen++;
      chk("done_pulse_width", 32'(done_prev), 32'd0);
      chk("done_err_exclusive", 32'(FRAME_ERR), 32'd0);
    end
    if (FRAME_ERR) begin
      err_seen++;
      chk("err_pulse_width", 32'(err_prev), 32'd0);
    end
    if (quiet) begin
      chk("idle_sdat", 32'(bus.ADC_SDAT), 32'd0);
      chk("idle_last_addr", 32'(LAST_ADDR), 32'(last_m));
    end
    done_prev = FRAME_DONE;
    err_prev  = FRAME_ERR;
  end

  // One controller frame: n_rise SCLK rising edges (16 = complete); simul makes
  // the 16th rise coincide with CS_N rising; chg_at rewrites the sending channel mid-frame.
  task automatic run_frame(input logic [2:0] addr, input int n_rise, input bit simul,
                           input int chg_at, input logic [11:0] chg_val,
                           output logic [15:0] got_w);
    logic [15:0] exp_w, mask;
    int d0, e0;
    bit full;
    exp_w = {4'b0000, model_val(conv_m)};
    full  = (n_rise == 16) && !simul;
    d0    = done_seen;
    e0    = err_seen;
    got_w = '0;
    mask  = '0;
    quiet = 0;
    cs_n  = 0;
    clk(H);
    for (int i = 0; i < n_rise; i++) begin
      sclk  = 0;
      saddr = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'($urandom);
      clk(H);
      got_w[15-i] = bus.ADC_SDAT;
      mask[15-i]  = 1'b1;
      if (i == chg_at) ch_arr[conv_m] = chg_val;
      sclk = 1;
      if (simul && i == 15) cs_n = 1;
      clk(H);
    end
    if (full) begin
      chk("hold_sdat", 32'(bus.ADC_SDAT), 32'd0);
      repeat (2) begin
        sclk = 0; clk(4);
        sclk = 1; clk(4);
        chk("hold_sdat_after_edges", 32'(bus.ADC_SDAT), 32'd0);
      end
    end
    cs_n = 1;
    clk(H);
    if (full) begin
      chk("frame_data", 32'(got_w), 32'(exp_w));
      chk("frame_done_count", 32'(done_seen - d0), 32'd1);
      chk("frame_err_count", 32'(err_seen - e0), 32'd0);
      chk("last_addr", 32'(LAST_ADDR), 32'(addr));
`ifdef ADC_SPI_RESPONDER_RAMP_EN
      ramp_m[conv_m] = ramp_m[conv_m] + 12'd1;
`endif
      conv_m = addr;
      last_m = addr;
    end else begin
      chk("abort_partial_data", 32'(got_w & mask), 32'(exp_w & mask));
      chk("abort_done_count", 32'(done_seen - d0), 32'd0);
      chk("abort_err_count", 32'(err_seen - e0), 32'd1);
      chk("abort_last_addr", 32'(LAST_ADDR), 32'(last_m));
    end
    quiet = 1;
    clk(4);
  endtask

  initial begin
    logic [15:0] w;
    int d0, e0, n;
    bit simul;
    int chg;

    for (int k = 0; k < 8; k++) ch_arr[k] = 12'($urandom);
    sclk = 1; cs_n = 1; saddr = 0;
    RESET = 0;
    model_reset();
    clk(3);
    chk("reset_sdat", 32'(bus.ADC_SDAT), 32'd0);
    chk("reset_done", 32'(FRAME_DONE), 32'd0);
    chk("reset_err", 32'(FRAME_ERR), 32'd0);
    chk("reset_last_addr", 32'(LAST_ADDR), 32'd0);
    RESET = 1;
    quiet = 1;
    clk(H);

    // Directed: CH0 then CH5, frozen data across a mid-frame change, abort.
    ch_arr[0] = 12'hABC;
    ch_arr[5] = 12'h123;
    run_frame(3'b101, 16, 0, -1, 12'h0, w);
`ifndef ADC_SPI_RESPONDER_RAMP_EN
    chk("lit_ch0_abc", 32'(w), 32'h0ABC);
`endif
    chk("lit_last_addr5", 32'(LAST_ADDR), 32'd5);
    run_frame(3'b101, 16, 0, -1, 12'h0, w);
`ifndef ADC_SPI_RESPONDER_RAMP_EN
    chk("lit_ch5_123", 32'(w), 32'h0123);
`endif
    run_frame(3'b101, 16, 0, 6, 12'h777, w);
`ifndef ADC_SPI_RESPONDER_RAMP_EN
    chk("lit_ch5_frozen", 32'(w), 32'h0123);
`endif
    run_frame(3'b010, 8, 0, -1, 12'h0, w);
    chk("lit_abort_last_addr", 32'(LAST_ADDR), 32'd5);
    run_frame(3'b000, 16, 0, -1, 12'h0, w);
`ifndef ADC_SPI_RESPONDER_RAMP_EN
    chk("lit_ch5_777", 32'(w), 32'h0777);
`endif

    // Boundaries: abort after 15 rises, and CS_N rise coinciding with the 16th rise.
    run_frame(3'b011, 15, 0, -1, 12'h0, w);
    run_frame(3'b011, 16, 1, -1, 12'h0, w);
    chk("simul_last_addr", 32'(LAST_ADDR), 32'd0);

    // Reset at bit 9 with CS_N low, released with CS_N still low.
    d0 = done_seen;
    e0 = err_seen;
    quiet = 0;
    cs_n = 0;
    clk(H);
    for (int i = 0; i < 9; i++) begin
      sclk = 0; saddr = 1'($urandom); clk(H);
      sclk = 1; clk(H);
    end
    sclk = 0;
    clk(H / 2);
    RESET = 0;
    model_reset();
    quiet = 1;
    clk(3);
    chk("midreset_sdat", 32'(bus.ADC_SDAT), 32'd0);
    chk("midreset_last_addr", 32'(LAST_ADDR), 32'd0);
    RESET = 1;
    for (int i = 0; i < 7; i++) begin
      sclk = 1; clk(H);
      sclk = 0; clk(H);
    end
    sclk = 1;
    clk(H);
    chk("midreset_done_count", 32'(done_seen - d0), 32'd0);
    chk("midreset_err_count", 32'(err_seen - e0), 32'd0);
    cs_n = 1;
    clk(H);
    run_frame(3'b010, 16, 0, -1, 12'h0, w);
`ifdef ADC_SPI_RESPONDER_RAMP_EN
    chk("lit_after_reset_ramp0", 32'(w), 32'h0000);
`else
    chk("lit_after_reset_ch0", 32'(w), 32'h0ABC);
`endif

    // Three frames on channel 2.
    ch_arr[2] = 12'h5A5;
    for (int i = 0; i < 3; i++) begin
      run_frame(3'b010, 16, 0, -1, 12'h0, w);
`ifdef ADC_SPI_RESPONDER_RAMP_EN
      chk("lit_ramp2", 32'(w), 32'h0200 + 32'(i));
`else
      chk("lit_ch2", 32'(w), 32'h05A5);
`endif
    end

    // Randomized frames, aborts and mid-frame channel changes.
    for (int f = 0; f < 30; f++) begin
      ch_arr[$urandom_range(0, 7)] = 12'($urandom);
      n     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 16;
      simul = (n == 16) && ($urandom_range(0, 5) == 0);
      chg   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1;
      run_frame(3'($urandom), n, simul, chg, 12'($urandom), w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
